// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and instruction constants, reused by decode and hazard units.
package fetch_pkg;

    // Fetch-stage control states.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Encoding that stops fetch when seen on the memory bus.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    // Encoding placed in IF/ID when an instruction is squashed.
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, next-PC and valid bit with hold and squash.
// Squash clears instr/valid, hold keeps everything, load captures a new
// instruction, and any other cycle leaves a bubble (valid dropped, data kept).
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              squash,
    input  logic              load,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] npc,
    output logic              valid
);

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic              valid_q, valid_d;

    // Next-value selection: squash beats hold, hold beats load, otherwise bubble.
    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (squash) begin
            instr_d = DATA_W'(NOP_WORD);
            valid_d = 1'b0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (load) begin
            instr_d = instr_in;
            npc_d   = npc_in;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= {DATA_W{1'b0}};
            npc_q   <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign npc   = npc_q;
    assign valid = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM, redirect/stall priority, halt and
// out-of-range detection, and a saturating delivered-instruction counter.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                MEM_DEPTH = 128,
    parameter logic [DATA_W-1:0] RESET_PC  = 32'd0,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_npc,
    output logic              if_id_valid,
    output logic              halted,
    output logic              fault,
    output logic [DATA_W-1:0] fetch_count
);

    localparam logic [DATA_W-1:0] PC_LIMIT  = DATA_W'(MEM_DEPTH);
    localparam logic [DATA_W-1:0] ONE       = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] COUNT_MAX = {DATA_W{1'b1}};

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              ifid_hold_s, ifid_squash_s, ifid_load_s;
    logic [DATA_W-1:0] pc_inc_s;

    assign pc_inc_s = pc_q + ONE;

    // Next-state and control: in RUN, redirect beats stall beats fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        ifid_hold_s   = 1'b0;
        ifid_squash_s = 1'b0;
        ifid_load_s   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Target is not range-checked here; an illegal target faults on its fetch.
                    pc_d          = redirect_pc;
                    ifid_squash_s = 1'b1;
                end else if (stall) begin
                    ifid_hold_s = 1'b1;
                end else if (pc_q >= PC_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (mem_data == HALT_WORD) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    ifid_load_s = 1'b1;
                    pc_d        = pc_inc_s;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + ONE;
                    end else begin
                        count_d = count_q;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC, flags and counter registers; reset overrides any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            count_q  <= {DATA_W{1'b0}};
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    if_id_reg #(
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (ifid_hold_s),
        .squash   (ifid_squash_s),
        .load     (ifid_load_s),
        .instr_in (mem_data),
        .npc_in   (pc_inc_s),
        .instr    (if_id_instr),
        .npc      (if_id_npc),
        .valid    (if_id_valid)
    );

    assign mem_addr    = pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// stimulus compared against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:127];

    int vectors;
    int errors;

    // Behavioural model of the architectural state.
    logic [31:0] m_pc, m_instr, m_npc, m_count;
    logic        m_valid, m_halted, m_fault, m_booting;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_instr (if_id_instr),
        .if_id_npc   (if_id_npc),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    assign mem_data = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model by the fetch rules, then sample after the edge.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
        rst = r; stall = s; redirect = rd; redirect_pc = rp;
        if (r) begin
            m_pc = 32'd0; m_instr = 32'd0; m_npc = 32'd0; m_count = 32'd0;
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_booting = 1'b1;
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_valid = 1'b0;
        end else if (m_halted || m_fault) begin
            m_valid = 1'b0;
        end else if (rd) begin
            m_pc = rp; m_valid = 1'b0; m_instr = 32'd0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (m_pc >= 32'd128) begin
            m_fault = 1'b1; m_valid = 1'b0;
        end else if (mem[m_pc[6:0]] == 32'hFFFF_FFFF) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc[6:0]];
            m_npc = m_pc + 32'd1;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        mem[0] = 32'hA000_00AA;
        for (int i = 1; i < 10; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'h11;
        mem[10] = 32'hFFFF_FFFF;
        for (int i = 11; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({mem_addr, if_id_instr, if_id_npc, if_id_valid, halted, fault, fetch_count} !==
            {32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got addr=%h instr=%h npc=%h v=%b h=%b f=%b cnt=%h, required all zero",
                     mem_addr, if_id_instr, if_id_npc, if_id_valid, halted, fault, fetch_count);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'hA000_00AA; exp_i[1] = 32'hA000_0011; exp_i[2] = 32'hA000_0022;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (if_id_valid !== 1'b0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL boot_cycle: got valid=%b addr=%h, required valid=0 addr=0", if_id_valid, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0);
            vectors++;
            if (if_id_instr !== exp_i[i] || if_id_npc !== 32'(i + 1) || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL free_run[%0d]: got instr=%h npc=%h v=%b, required instr=%h npc=%h v=1",
                         i, if_id_instr, if_id_npc, if_id_valid, exp_i[i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            vectors++;
            if (if_id_instr !== 32'hA000_0022 || if_id_npc !== 32'd3 || if_id_valid !== 1'b1 ||
                mem_addr !== 32'd3 || fetch_count !== 32'd3) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got instr=%h npc=%h v=%b addr=%h cnt=%h, required A0000022/3/1/3/3",
                         i, if_id_instr, if_id_npc, if_id_valid, mem_addr, fetch_count);
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (if_id_instr !== 32'hA000_0033 || if_id_npc !== 32'd4 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL stall_resume: got instr=%h npc=%h cnt=%h, required A0000033/4/4",
                     if_id_instr, if_id_npc, fetch_count);
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 1'b1, 1'b1, 32'd8);
        vectors++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || mem_addr !== 32'd8 || fetch_count !== 32'd4) begin
            errors++;
            $display("FAIL redirect_squash: got v=%b instr=%h addr=%h cnt=%h, required 0/0/8/4",
                     if_id_valid, if_id_instr, mem_addr, fetch_count);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (if_id_instr !== 32'hA000_0088 || if_id_npc !== 32'd9 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_target: got instr=%h npc=%h v=%b, required A0000088/9/1",
                     if_id_instr, if_id_npc, if_id_valid);
        end
    endtask

    task automatic test_halt();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 20 && halted !== 1'b1; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (halted !== 1'b1 || if_id_valid !== 1'b0 || fetch_count !== 32'd10 || mem_addr !== 32'd10) begin
            errors++;
            $display("FAIL halt_detect: got h=%b v=%b cnt=%h addr=%h, required 1/0/10/10",
                     halted, if_id_valid, fetch_count, mem_addr);
        end
        step(1'b0, 1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        vectors++;
        if (halted !== 1'b1 || if_id_valid !== 1'b0 || mem_addr !== 32'd10 || fetch_count !== 32'd10) begin
            errors++;
            $display("FAIL halt_sticky: got h=%b v=%b addr=%h cnt=%h, required 1/0/10/10",
                     halted, if_id_valid, mem_addr, fetch_count);
        end
    endtask

    task automatic test_fault();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'd200);
        vectors++;
        if (fault !== 1'b0 || if_id_valid !== 1'b0 || mem_addr !== 32'd200) begin
            errors++;
            $display("FAIL fault_redirect: got f=%b v=%b addr=%h, required 0/0/200", fault, if_id_valid, mem_addr);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (fault !== 1'b1 || if_id_valid !== 1'b0 || mem_addr !== 32'd200 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL fault_detect: got f=%b v=%b addr=%h cnt=%h, required 1/0/200/0",
                     fault, if_id_valid, mem_addr, fetch_count);
        end
        step(1'b0, 1'b0, 1'b1, 32'd5);
        vectors++;
        if (fault !== 1'b1 || mem_addr !== 32'd200) begin
            errors++;
            $display("FAIL fault_sticky: got f=%b addr=%h, required 1/200", fault, mem_addr);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (fault !== 1'b0 || mem_addr !== 32'd0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL fault_reset: got f=%b addr=%h cnt=%h, required 0/0/0", fault, mem_addr, fetch_count);
        end
    endtask

    task automatic test_reset_redirect();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'd5);
        vectors++;
        if (mem_addr !== 32'd0 || if_id_valid !== 1'b0 || fetch_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_redirect: got addr=%h v=%b cnt=%h, required 0/0/0", mem_addr, if_id_valid, fetch_count);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (if_id_instr !== 32'hA000_00AA || if_id_npc !== 32'd1 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_reboot: got instr=%h npc=%h v=%b, required A00000AA/1/1",
                     if_id_instr, if_id_npc, if_id_valid);
        end
    endtask

    task automatic test_random();
        for (int epoch = 0; epoch < 6; epoch++) begin
            for (int i = 0; i < 128; i++) begin
                mem[i] = ($urandom_range(0, 59) == 0) ? 32'hFFFF_FFFF : ($urandom() & 32'h7FFF_FFFF);
            end
            step(1'b1, 1'b0, 1'b0, 32'd0);
            for (int c = 0; c < 80; c++) begin
                logic r, s, rd;
                logic [31:0] rp;
                r  = ($urandom_range(0, 49) == 0);
                s  = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 9) == 0);
                rp = 32'($urandom_range(0, 140));
                step(r, s, rd, rp);
                vectors++;
                if ({mem_addr, if_id_instr, if_id_npc, if_id_valid, halted, fault, fetch_count} !==
                    {m_pc, m_instr, m_npc, m_valid, m_halted, m_fault, m_count}) begin
                    errors++;
                    $display("FAIL random[%0d.%0d]: got addr=%h instr=%h npc=%h v=%b h=%b f=%b cnt=%h, required addr=%h instr=%h npc=%h v=%b h=%b f=%b cnt=%h",
                             epoch, c, mem_addr, if_id_instr, if_id_npc, if_id_valid, halted, fault, fetch_count,
                             m_pc, m_instr, m_npc, m_valid, m_halted, m_fault, m_count);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        preload();
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_reset_redirect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
